fifo_level: RTL
===============

# fifo_level

Synchronous single-clock FIFO with a registered occupancy count, programmable almost-full and almost-empty thresholds, defined full/empty simultaneous-access behaviour and optional sticky overflow/underflow error flags. It replaces the basic pointer-only FIFO wherever a producer or consumer needs early back-pressure or level visibility, such as UART receive buffers and stream rate adapters. Read data is show-ahead: the head word is always visible on `r_data`.

## Interface
- `B`, 8, data word width in bits
- `W`, 4, address bits; depth is 2**W
- `AF_LEVEL`, 2**W-2, `almost_full` asserts when level >= AF_LEVEL (legal range 1..2**W)
- `AE_LEVEL`, 2, `almost_empty` asserts when level <= AE_LEVEL (legal range 0..2**W-1)
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `wr`  in  1  write request
- `w_data`  in  B  write data
- `rd`  in  1  read request; pops the head word
- `r_data`  out  B  head-of-FIFO word (combinational from storage and read pointer)
- `empty`  out  1  level == 0
- `full`  out  1  level == 2**W
- `almost_empty`  out  1  level <= AE_LEVEL
- `almost_full`  out  1  level >= AF_LEVEL
- `level`  out  W+1  current occupancy, 0..2**W
- `err_clr`  in  1  clears sticky error flags (present only with `FIFO_LEVEL_ERR_EN`)
- `overflow`  out  1  sticky write-while-full flag (present only with `FIFO_LEVEL_ERR_EN`)
- `underflow`  out  1  sticky read-while-empty flag (present only with `FIFO_LEVEL_ERR_EN`)

## Operation
- State: W-bit write and read pointers, (W+1)-bit level register, storage array of 2**W words; storage is not reset.
- Effective write: `we = wr & (~full | rd)`. Effective read: `re = rd & ~empty`.
- On `we`, write `w_data` at the write pointer and increment the pointer mod 2**W. On `re`, increment the read pointer mod 2**W.
- Level update: +1 when we&~re, -1 when re&~we, unchanged otherwise.
- Empty with wr&rd: the write is performed and the read is ignored; level becomes 1.
- Full with wr&rd: both are performed and level stays 2**W. The consumer samples the old head before the edge, so overwriting the freed slot is safe.
- Write while full without rd is dropped, and pointers are unchanged. Read while empty is ignored.
- `empty`, `full`, `almost_*` are decoded only from the registered level. There is no combinational path from `wr`/`rd` to any flag.
- Pointers wrap naturally. Full/empty are disambiguated by level, not by pointer compare.

## Timing
- Reset (async assert, sampled deassert): pointers = 0, level = 0, `empty` = 1, `full` = 0, `almost_empty` = 1, `almost_full` = 0, `overflow` = `underflow` = 0, `r_data` undefined.
- Reset mid-operation discards all contents immediately, and flags take reset values without waiting for a clock.
- Write-to-read latency is 1 cycle: a word written into an empty FIFO at edge N appears on `r_data` with `empty` = 0 after edge N.
- Flags and level update on the same edge as the pointer change.

## Configuration
- `FIFO_LEVEL_ERR_EN` defined: `err_clr`, `overflow` and `underflow` ports exist.
  - `overflow` sets on any cycle with wr & full & ~rd.
  - `underflow` sets on any cycle with rd & empty, including the wr&rd-while-empty case.
  - Both flags stay set until a cycle with `err_clr` = 1. If clear and set coincide, set wins.
- `FIFO_LEVEL_ERR_EN` undefined: the three ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset, then write 0x11..0x1F, 0x10 (16 words, W=4): `level` steps 1..16; `almost_full` asserts at level 14; `full` asserts after the 16th edge; `r_data` = 0x11 throughout.
- From full, read 16 times: data order 0x11..0x1F, 0x10; `almost_empty` asserts at level 2; `empty` = 1 and level = 0 after the 16th read.
- Empty FIFO, wr=rd=1 with w_data=0xA5 for one cycle: level = 1, `r_data` = 0xA5, `underflow` = 1 (ERR_EN build).
- Full FIFO, wr=rd=1 with w_data=0x5A: level stays 16, the popped word equals the previous head, and 0x5A is read last after 15 further pops.
- Full FIFO, wr=1 rd=0: contents unchanged, `overflow` = 1 and held; `err_clr` for one cycle clears it; `err_clr` coinciding with a new overflow leaves it at 1.
- Assert `reset` asynchronously mid-stream at level 7: `empty` = 1 and `level` = 0 before the next clock edge; a subsequent write of 0x3C reads back 0x3C.

Source files
------------

// File: rtl/fifo_level.sv
// Single-clock show-ahead FIFO with a registered occupancy count and programmable almost-full/almost-empty thresholds.
// Define FIFO_LEVEL_ERR_EN to add the err_clr input and the sticky overflow/underflow flags.
module fifo_level #(
  parameter int B        = 8,
  parameter int W        = 4,
  parameter int AF_LEVEL = 2**W - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   level
`ifdef FIFO_LEVEL_ERR_EN
  ,
  input  logic         err_clr,
  output logic         overflow,
  output logic         underflow
`endif
);

  localparam logic [W-1:0] PTR_ONE = W'(1);
  localparam logic [W:0]   LVL_ONE = (W+1)'(1);
  localparam logic [W:0]   LVL_ZERO = (W+1)'(0);
  localparam logic [W:0]   DEPTH_L = (W+1)'(2**W);
  localparam logic [W:0]   AF_L    = (W+1)'(AF_LEVEL);
  localparam logic [W:0]   AE_L    = (W+1)'(AE_LEVEL);

  logic [B-1:0] mem_r [2**W];
  logic [W-1:0] wr_ptr_r;
  logic [W-1:0] rd_ptr_r;
  logic [W:0]   level_r;
  logic [W:0]   level_next_s;
  logic         empty_r;
  logic         full_r;
  logic         almost_empty_r;
  logic         almost_full_r;
  logic         we_s;
  logic         re_s;

  // A write into a full FIFO is only accepted when a read frees the head slot on the same edge.
  assign we_s = wr & (~full_r | rd);
  assign re_s = rd & ~empty_r;

  // Occupancy for the next edge; flags are decoded from it and registered alongside the level.
  always_comb begin
    level_next_s = level_r;
    case ({we_s, re_s})
      2'b10:   level_next_s = level_r + LVL_ONE;
      2'b01:   level_next_s = level_r - LVL_ONE;
      default: level_next_s = level_r;
    endcase
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[wr_ptr_r] <= w_data;
    end
  end

  // Pointers, level and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r       <= {W{1'b0}};
      rd_ptr_r       <= {W{1'b0}};
      level_r        <= LVL_ZERO;
      empty_r        <= 1'b1;
      full_r         <= 1'b0;
      almost_empty_r <= 1'b1;
      almost_full_r  <= 1'b0;
    end else begin
      if (we_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (re_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r        <= level_next_s;
      empty_r        <= (level_next_s == LVL_ZERO);
      full_r         <= (level_next_s == DEPTH_L);
      almost_empty_r <= (level_next_s <= AE_L);
      almost_full_r  <= (level_next_s >= AF_L);
    end
  end

  assign r_data       = mem_r[rd_ptr_r];
  assign empty        = empty_r;
  assign full         = full_r;
  assign almost_empty = almost_empty_r;
  assign almost_full  = almost_full_r;
  assign level        = level_r;

`ifdef FIFO_LEVEL_ERR_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags; a new error on the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= (wr & full_r & ~rd) | (overflow_r & ~err_clr);
      underflow_r <= (rd & empty_r) | (underflow_r & ~err_clr);
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`endif

endmodule
